ifu_axi: RTL and testbench
==========================

// Module: ifu_axi
// PURPOSE
//  Instruction fetch stage directly upstream of the decode stage. Owns the PC, issues one
//  AXI4-Lite read per instruction, extracts the 32-bit word and presents it with its PC
//  on a valid/ready handshake to decode. Accepts PC redirects from execute (branch/jump/trap).
//  One outstanding read at a time; no prefetch.
// PARAMETERS
//  XLEN      64            PC width
//  DATA_W    64            AXI read data width (32 or 64)
//  RESET_PC  64'h8000_0000 PC fetched first after reset
// PORTS
//  clk             in   1       single clock, rising edge
//  rst             in   1       asynchronous, active-low reset
//  redirect_valid  in   1       load redirect_pc as next fetch PC
//  redirect_pc     in   XLEN    redirect target
//  araddr          out  XLEN    AXI AR address (= fetch PC, bits [1:0] = 0)
//  arvalid         out  1       AXI AR valid
//  arready         in   1       AXI AR ready
//  rdata           in   DATA_W  AXI R data
//  rresp           in   2       AXI R response
//  rvalid          in   1       AXI R valid
//  rready          out  1       AXI R ready
//  inst            out  32      instruction to decode
//  inst_pc         out  XLEN    PC of inst
//  inst_fault      out  1       rresp != OKAY for this inst
//  inst_valid      out  1       inst/inst_pc/inst_fault valid
//  inst_ready      in   1       decode accepts
// BEHAVIOUR
//  - Reset (rst=0, async): state=S_AR, pc=RESET_PC, arvalid=0, rready=0, inst_valid=0,
//    inst=0, inst_pc=0, inst_fault=0, flush=0. First arvalid in first clock after release.
//  - FSM: S_AR: arvalid=1, araddr=pc; arvalid&arready -> S_R.
//    S_R: rready=1; rvalid -> latch inst (rdata[63:32] if DATA_W=64 & pc[2], else [31:0]),
//    inst_pc=pc, inst_fault=(rresp!=2'b00); -> S_HOLD with inst_valid=1 next cycle.
//    S_HOLD: inst_valid=1 until inst_valid&inst_ready; then pc<=pc+4, inst_valid<=0, -> S_AR.
//  - Minimum latency: AR accept cycle N, rvalid N+1, inst_valid N+2; next arvalid cycle
//    after decode handshake.
//  - AR signals held stable once asserted until arready (AXI rule); redirect never drops arvalid.
//  - Redirect in S_AR or S_R: pc<=redirect_pc, flush<=1; pending beat is completed and
//    discarded (no inst_valid); flush clears on that beat; -> S_AR with new pc.
//  - Redirect in S_HOLD: inst_valid<=0 (unconsumed inst dropped), pc<=redirect_pc, -> S_AR.
//  - Redirect same cycle as inst_valid&inst_ready: inst counts as accepted; next pc=redirect_pc.
//  - Redirect every cycle: last value wins; flush stays set.
//  - PC arithmetic modulo 2^XLEN; pc+4 wraps silently.
//  - rresp error is not retried; inst delivered with inst_fault=1, pc advances normally.
// CONFIGURATION
//  IFU_MISALIGN_CHK_EN defined: redirect_pc[1:0]!=0 issues no AXI read; IFU goes straight to
//    S_HOLD with inst=32'h0000_0013, inst_pc=redirect_pc, extra output inst_misalign=1
//    (0 otherwise). Undefined: port absent; redirect_pc[1:0] forced to 2'b00, fetch normal.
// STRUCTURE
//  - common.v: `RESP_OKAY 2'b00, `NOP_INST 32'h0000_0013, FSM state encodings, RESET_PC
//    default; XLEN via existing `XLEN.
//  - Single module; FSM, PC register and lane select inline. No sub-module required.
// TESTING
//  - Reset release, memory at 0x8000_0000=0x00000513, arready=1, rvalid next cycle, ready=1
//    -> araddr=0x8000_0000, inst=0x00000513, inst_pc=0x8000_0000, then araddr=0x8000_0004.
//  - DATA_W=64, pc=0x8000_0004, rdata=0x00A00593_00000513 -> inst=0x00A00593.
//  - arready low 5 cycles -> arvalid/araddr stable throughout; one inst delivered.
//  - inst_ready low 3 cycles in S_HOLD -> inst/inst_pc stable, no new arvalid; then pc+4.
//  - redirect_valid=1, redirect_pc=0x8000_0100 during S_R -> in-flight beat discarded,
//    next inst_pc=0x8000_0100, no inst_valid for old PC.
//  - rresp=2'b10 -> inst_fault=1 with inst_valid; with IFU_MISALIGN_CHK_EN,
//    redirect_pc=0x8000_0102 -> no arvalid, inst_misalign=1, inst=0x00000013.

Source files
------------

// File: rtl/ifu_axi_pkg.sv
// Shared constants and state encoding for the AXI4-Lite instruction fetch unit.
// Response codes, NOP encoding and reset PC default.
package ifu_axi_pkg;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_AR,
    S_R,
    S_HOLD
  } state_t;

endpackage

// File: rtl/ifu_axi.sv
// Fetch stage: one AXI4-Lite read per instruction, handed to decode on valid/ready.
// IFU_MISALIGN_CHK_EN adds inst_misalign and skips the bus for unaligned redirects.
module ifu_axi
  import ifu_axi_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DATA_W   = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault,
  output logic              inst_valid,
  input  logic              inst_ready
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic              inst_misalign
`endif
);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] redir_pc;
  logic            flush;
  logic            launch;
  logic            hs;
  logic            r_hs;
  logic [31:0]     lane;

  assign hs   = inst_valid & inst_ready;
  assign r_hs = rvalid & rready;

`ifdef IFU_MISALIGN_CHK_EN
  assign redir_pc = redirect_pc;
`else
  assign redir_pc = redirect_pc & ~XLEN'(3);
`endif

  if (DATA_W == 64) begin : g_w64
    assign lane = araddr[2] ? rdata[DATA_W-1:32] : rdata[31:0];
  end else begin : g_w32
    assign lane = rdata[31:0];
  end

  // launch: leave the current state for a fresh fetch of npc
  always_comb begin
    launch = 1'b0;
    npc    = pc;
    unique case (state)
      S_AR: if (!arvalid) begin
        launch = 1'b1;
        npc    = redirect_valid ? redir_pc : pc;
      end
      S_R: if (r_hs) begin
        launch = flush | redirect_valid;
        npc    = redirect_valid ? redir_pc : pc;
      end
      S_HOLD: if (hs | redirect_valid) begin
        launch = 1'b1;
        npc    = redirect_valid ? redir_pc : pc + XLEN'(4);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_AR;
      pc         <= RESET_PC;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
      flush      <= 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
      inst_misalign <= 1'b0;
`endif
    end else begin
      if (redirect_valid) pc <= redir_pc;
      unique case (state)
        S_AR: begin
          if (arvalid && redirect_valid) flush <= 1'b1;
          if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end
        S_R: begin
          if (r_hs) begin
            rready <= 1'b0;
            flush  <= 1'b0;
            if (!launch) begin
              inst       <= lane;
              inst_pc    <= araddr;
              inst_fault <= (rresp != RESP_OKAY);
              inst_valid <= 1'b1;
              state      <= S_HOLD;
`ifdef IFU_MISALIGN_CHK_EN
              inst_misalign <= 1'b0;
`endif
            end
          end else if (redirect_valid) begin
            flush <= 1'b1;
          end
        end
        S_HOLD: if (hs || redirect_valid) inst_valid <= 1'b0;
        default: ;
      endcase
      if (launch) begin
        pc <= npc;
`ifdef IFU_MISALIGN_CHK_EN
        if (npc[1:0] != 2'b00) begin
          state         <= S_HOLD;
          inst_valid    <= 1'b1;
          inst          <= NOP_INST;
          inst_pc       <= npc;
          inst_fault    <= 1'b0;
          inst_misalign <= 1'b1;
        end else begin
          state   <= S_AR;
          arvalid <= 1'b1;
          araddr  <= npc;
        end
`else
        state   <= S_AR;
        arvalid <= 1'b1;
        araddr  <= npc;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ifu_axi.sv
// Randomized bench for ifu_axi: AXI slave model plus expected-PC reference model.
// Honours IFU_MISALIGN_CHK_EN when defined.
module tb_ifu_axi;

  localparam int XLEN   = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic [XLEN-1:0]   araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [31:0]       inst;
  logic [XLEN-1:0]   inst_pc;
  logic              inst_fault;
  logic              inst_valid;
  logic              inst_ready;
`ifdef IFU_MISALIGN_CHK_EN
  logic              inst_misalign;
`endif

  always #5 clk = ~clk;

  ifu_axi #(.XLEN(XLEN), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .araddr(araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata),
    .rresp(rresp),
    .rvalid(rvalid),
    .rready(rready),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_fault(inst_fault),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .inst_misalign(inst_misalign)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0000_0513;
    if (a == 64'h8000_0004) return 32'h00A0_0593;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic bit is_fault(input logic [63:0] a);
    return a[6:2] == 5'h13;
  endfunction

  function automatic logic [63:0] eff_target(input logic [63:0] a);
`ifdef IFU_MISALIGN_CHK_EN
    return a;
`else
    return a & ~64'h3;
`endif
  endfunction

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    if ($urandom_range(0, 7) == 0)
      t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 4;
    else
      t = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 4;
`ifndef IFU_MISALIGN_CHK_EN
    t = t | 64'($urandom_range(0, 3));
`endif
    return t;
  endfunction

  logic [63:0] exp_pc;
  logic [63:0] r_addr;
  logic [63:0] base;
  logic [63:0] p_araddr;
  logic [63:0] p_inst_pc;
  logic [31:0] p_inst;
  bit          r_pend;
  int          r_dly;
  int          deliveries;
  int          idle;
  bit          ideal;
  bit          sr_done;
  bit          ar_hs;
  bit          r_hs;
  bit          dec_hs;
  bit          mis;
  bit          p_ar_stall;
  bit          p_iv_hold;
  bit          p_dec_hs;
  bit          p_lat_iv;
  bit          p_lat_rr;

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    arready        = 1'b0;
    rdata          = '0;
    rresp          = 2'b00;
    rvalid         = 1'b0;
    inst_ready     = 1'b0;
    rst            = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_inst_fault", 64'(inst_fault), 64'd0);
    rst = 1'b1;

    exp_pc     = 64'h8000_0000;
    r_pend     = 1'b0;
    r_dly      = 0;
    r_addr     = '0;
    deliveries = 0;
    idle       = 0;
    sr_done    = 1'b0;
    p_ar_stall = 1'b0;
    p_iv_hold  = 1'b0;
    p_dec_hs   = 1'b0;
    p_lat_iv   = 1'b0;
    p_lat_rr   = 1'b0;
    p_araddr   = '0;
    p_inst_pc  = '0;
    p_inst     = '0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("first_arvalid", 64'(arvalid), 64'd1);
        chk("first_araddr", araddr, 64'h8000_0000);
      end
      if (p_ar_stall) begin
        chk("ar_hold_valid", 64'(arvalid), 64'd1);
        chk("ar_hold_addr", araddr, p_araddr);
      end
      if (p_iv_hold) begin
        chk("hold_valid", 64'(inst_valid), 64'd1);
        chk("hold_inst", 64'(inst), 64'(p_inst));
        chk("hold_pc", inst_pc, p_inst_pc);
        chk("hold_no_ar", 64'(arvalid), 64'd0);
      end
      if (p_dec_hs && exp_pc[1:0] == 2'b00)
        chk("ar_after_hs", 64'(arvalid), 64'd1);
      if (p_lat_rr) chk("lat_rready", 64'(rready), 64'd1);
      if (p_lat_iv) chk("lat_inst_valid", 64'(inst_valid), 64'd1);
      if (arvalid) chk("araddr_align", 64'(araddr[1:0]), 64'd0);

      ideal = (cyc < 40) || (cyc >= 60 && cyc < 100);
      if (cyc >= 40 && cyc < 45) arready = 1'b0;
      else if (cyc < 100) arready = 1'b1;
      else arready = ($urandom_range(0, 2) != 0);
      if (cyc >= 50 && cyc < 53) inst_ready = 1'b0;
      else if (cyc < 100) inst_ready = 1'b1;
      else inst_ready = ($urandom_range(0, 3) != 0);

      redirect_valid = 1'b0;
      if (cyc >= 60 && cyc < 100 && !sr_done && rready) begin
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        sr_done        = 1'b1;
      end else if (cyc >= 100 && cyc < 110) begin
        redirect_valid = 1'b1;
        redirect_pc    = pick_target();
      end else if (cyc >= 110 && $urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = pick_target();
      end
`ifdef IFU_MISALIGN_CHK_EN
      if (cyc == 2900) begin
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
      end
`endif

      rvalid = r_pend && r_dly == 0;
      base   = r_addr & ~64'h7;
      rdata  = {mem_word(base + 64'd4), mem_word(base)};
      rresp  = is_fault(r_addr) ? 2'b10 : 2'b00;

      ar_hs  = arvalid && arready;
      r_hs   = rvalid && rready;
      dec_hs = inst_valid && inst_ready;

      if (r_hs) r_pend = 1'b0;
      else if (r_pend && r_dly > 0) r_dly--;
      if (ar_hs) begin
        r_pend = 1'b1;
        r_addr = araddr;
        r_dly  = ideal ? 0 : $urandom_range(0, 3);
      end

      idle++;
      if (dec_hs) begin
        mis = (exp_pc[1:0] != 2'b00);
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst", 64'(inst), 64'(mis ? 32'h0000_0013 : mem_word(exp_pc)));
        chk("inst_fault", 64'(inst_fault), 64'(!mis && is_fault(exp_pc)));
`ifdef IFU_MISALIGN_CHK_EN
        chk("inst_misalign", 64'(inst_misalign), 64'(mis));
`endif
        if (deliveries == 0) chk("first_inst", 64'(inst), 64'h0000_0513);
        if (deliveries == 1) chk("hi_lane_inst", 64'(inst), 64'h00A0_0593);
        deliveries++;
        idle   = 0;
        exp_pc = exp_pc + 64'd4;
      end
      if (redirect_valid) exp_pc = eff_target(redirect_pc);
      if (idle > 300) begin
        chk("progress", 64'd0, 64'd1);
        idle = 0;
      end

      p_ar_stall = arvalid && !arready;
      p_araddr   = araddr;
      p_iv_hold  = inst_valid && !inst_ready && !redirect_valid;
      p_inst     = inst;
      p_inst_pc  = inst_pc;
      p_dec_hs   = dec_hs;
      p_lat_rr   = (cyc < 40) && ar_hs;
      p_lat_iv   = (cyc < 40) && r_hs;
    end

    chk("deliveries_min", 64'(deliveries >= 100), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
